// File: rtl/ps2_bike_ctrl_pkg.sv
// Shared constants for the PS/2 bike controller: set-2 scancodes, heading
// encoding and the parser state encoding.
package ps2_bike_ctrl_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_RT    = 8'h74;
  localparam logic [7:0] SC_DN    = 8'h72;
  localparam logic [7:0] SC_LT    = 8'h6B;
  localparam logic [7:0] SC_SPACE = 8'h29;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_E0   = 2'd1,
    ST_F0   = 2'd2,
    ST_E0F0 = 2'd3
  } parse_state_e;

  // Opposite heading is always the one differing in the MSB.
  function automatic logic is_reversal(input logic [1:0] cur, input logic [1:0] req);
    return req == (cur ^ 2'b10);
  endfunction

endpackage

// File: rtl/ps2_bike_ctrl_dir_reg.sv
// Per-player heading register: drops reversals, latches accepted headings
// and holds valid until the processor acknowledges.
module bike_dir_reg
  import ps2_bike_ctrl_pkg::*;
#(
  parameter logic [1:0] INIT_DIR = DIR_RIGHT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_i,
  input  logic [1:0] req_dir_i,
  input  logic       ack_i,
  output logic [1:0] dir_o,
  output logic       valid_o
);

  logic [1:0] dir_q;
  logic       valid_q;
  logic       accept;

  assign accept = req_i && !is_reversal(dir_q, req_dir_i) && (req_dir_i != dir_q);

  // An acceptance in the same cycle as ack wins, so a fresh heading is never lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      dir_q   <= INIT_DIR;
      valid_q <= 1'b0;
    end else if (accept) begin
      dir_q   <= req_dir_i;
      valid_q <= 1'b1;
    end else if (ack_i) begin
      valid_q <= 1'b0;
    end
  end

  assign dir_o   = dir_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/ps2_bike_ctrl.sv
// Set-2 scancode parser mapping WASD / arrows to bike headings plus Space to
// a start pulse; prefixes abandoned after TIMEOUT_CYCLES idle cycles.
//
// state   | meaning
// IDLE    | waiting for a make code or prefix
// E0      | extended prefix seen, next byte is extended make or F0
// F0      | break prefix seen, next byte is ignored
// E0F0    | extended break prefix seen, next byte is ignored
module ps2_bike_ctrl
  import ps2_bike_ctrl_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [1:0] INIT_DIR_BLUE  = 2'b01,
  parameter logic [1:0] INIT_DIR_RED   = 2'b11
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  output logic [1:0] blue_dir,
  output logic       blue_valid,
  input  logic       blue_ack,
  output logic [1:0] red_dir,
  output logic       red_valid,
  input  logic       red_ack,
  output logic       start_pulse,
  output logic       proto_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  parse_state_e   state_q;
  logic [CNT_W-1:0] tmo_q;
  logic           start_q;
  logic           err_q;

  logic       blue_req, red_req;
  logic [1:0] blue_req_dir, red_req_dir;
  logic       is_prefix;

  assign is_prefix = (ps2_key_data == SC_E0) || (ps2_key_data == SC_F0);

  always_comb begin
    blue_req     = 1'b0;
    blue_req_dir = DIR_UP;
    red_req      = 1'b0;
    red_req_dir  = DIR_UP;
    if (ps2_key_pressed && !is_prefix) begin
      if (state_q == ST_IDLE) begin
        case (ps2_key_data)
          SC_W:    begin blue_req = 1'b1; blue_req_dir = DIR_UP;    end
          SC_D:    begin blue_req = 1'b1; blue_req_dir = DIR_RIGHT; end
          SC_S:    begin blue_req = 1'b1; blue_req_dir = DIR_DOWN;  end
          SC_A:    begin blue_req = 1'b1; blue_req_dir = DIR_LEFT;  end
          default: ;
        endcase
      end else if (state_q == ST_E0) begin
        case (ps2_key_data)
          SC_UP:   begin red_req = 1'b1; red_req_dir = DIR_UP;    end
          SC_RT:   begin red_req = 1'b1; red_req_dir = DIR_RIGHT; end
          SC_DN:   begin red_req = 1'b1; red_req_dir = DIR_DOWN;  end
          SC_LT:   begin red_req = 1'b1; red_req_dir = DIR_LEFT;  end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
      if (ps2_key_pressed) begin
        tmo_q <= '0;
        case (state_q)
          ST_IDLE: begin
            if (ps2_key_data == SC_E0)      state_q <= ST_E0;
            else if (ps2_key_data == SC_F0) state_q <= ST_F0;
            else if (ps2_key_data == SC_SPACE) start_q <= 1'b1;
          end
          ST_E0: begin
            if (ps2_key_data == SC_F0) begin
              state_q <= ST_E0F0;
            end else begin
              state_q <= ST_IDLE;
              err_q   <= (ps2_key_data == SC_E0);
            end
          end
          ST_F0: begin
            state_q <= ST_IDLE;
            err_q   <= (ps2_key_data == SC_F0);
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (state_q != ST_IDLE) begin
        // A byte arriving on the terminal cycle takes priority over the timeout.
        if (tmo_q == CNT_LAST) begin
          state_q <= ST_IDLE;
          tmo_q   <= '0;
          err_q   <= 1'b1;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
      end
    end
  end

  assign start_pulse = start_q;
  assign proto_err   = err_q;

  bike_dir_reg #(.INIT_DIR(INIT_DIR_BLUE)) u_blue (
    .clock     (clock),
    .reset     (reset),
    .req_i     (blue_req),
    .req_dir_i (blue_req_dir),
    .ack_i     (blue_ack),
    .dir_o     (blue_dir),
    .valid_o   (blue_valid)
  );

  bike_dir_reg #(.INIT_DIR(INIT_DIR_RED)) u_red (
    .clock     (clock),
    .reset     (reset),
    .req_i     (red_req),
    .req_dir_i (red_req_dir),
    .ack_i     (red_ack),
    .dir_o     (red_dir),
    .valid_o   (red_valid)
  );

endmodule
